// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// uart_tx_serializer_if: parallel-word request side and serial line of the UART transmitter.
// Rev 1.0
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) ();
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      Busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, Busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// uart_tx_serializer: UART frame serialiser (start, LSB-first data, optional parity, stop).
// Rev 1.0
module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input wire CLK,
  input wire RST,
  uart_tx_serializer_if.slave bus
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state, state_next;
  logic [PRESCALE_WIDTH-1:0] edge_cnt, edge_next, period;
  logic [BIT_W-1:0]          bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0]     data_reg;
  logic                      par_en_reg, par_typ_reg;
  logic                      tx_out, busy, tx_next, busy_next;
  logic                      accept, bit_end, last_bit, parity_bit;

  assign accept     = (state == IDLE) && bus.DATA_VALID;
  assign bit_end    = (edge_cnt == period - PRESCALE_WIDTH'(1));
  assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign parity_bit = par_typ_reg ? ~^data_reg : ^data_reg;

  always_comb begin
    state_next = state;
    edge_next  = edge_cnt + PRESCALE_WIDTH'(1);
    bit_next   = bit_cnt;
    tx_next    = 1'b1;
    busy_next  = 1'b0;

    case (state)
      IDLE: begin
        edge_next = '0;
        if (accept) state_next = START;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          edge_next  = '0;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          edge_next = '0;
          if (last_bit) state_next = par_en_reg ? PARITY : STOP;
          else          bit_next   = bit_cnt + BIT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          edge_next  = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          edge_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        edge_next  = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[bit_next];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      period      <= '0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state    <= state_next;
      edge_cnt <= edge_next;
      bit_cnt  <= bit_next;
      tx_out   <= tx_next;
      busy     <= busy_next;
      if (accept) begin
        data_reg    <= bus.P_DATA;
        par_en_reg  <= bus.PAR_EN;
        par_typ_reg <= bus.PAR_TYP;
        period      <= (bus.prescale == '0) ? PRESCALE_WIDTH'(1) : bus.prescale;
      end
    end
  end

  assign bus.TX_OUT = tx_out;
  assign bus.Busy   = busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// tb_uart_tx_serializer: randomized self-checking bench against a bit-list frame model.
// Rev 1.0
module tb_uart_tx_serializer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic exp_tx[$];
  logic exp_busy[$];

  uart_tx_serializer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d required 0", errors);
    $fatal(1, "watchdog expired");
  end

  // Model: a frame is a list of line levels, each repeated max(prescale,1) times.
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt,
                                     input int presc);
    int   p;
    int   ones;
    logic bits[$];
    p    = (presc < 1) ? 1 : presc;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? (((ones + 1) % 2) == 1) : ((ones % 2) == 1));
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r < p; r++) begin
        exp_tx.push_back(bits[k]);
        exp_busy.push_back(1'b1);
      end
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endfunction

  function automatic void clear_model();
    exp_tx.delete();
    exp_busy.delete();
  endfunction

  // Present a request for one edge; afterwards the inputs are scrambled to prove latching.
  task automatic launch(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] presc, input bit hold);
    @(negedge clk);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.prescale   = presc;
    bus.DATA_VALID = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.DATA_VALID = 1'b0;
      bus.P_DATA     = 8'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.PAR_TYP    = 1'($urandom);
      bus.prescale   = 6'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    bus.prescale = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b required tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    rst = 1'b1;
    clear_model();
    push_idle(3);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_basic();
    clear_model();
    push_frame(8'hA5, 1'b0, 1'b0, 8);
    push_idle(2);
    launch(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL basic_a5 cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic       pe, pt;
    int         presc;
    for (int n = 0; n < 6; n++) begin
      d     = (n < 2) ? 8'h07 : 8'($urandom);
      pe    = (n < 2) ? 1'b1 : 1'($urandom);
      pt    = (n < 2) ? 1'(n) : 1'($urandom);
      presc = (n < 2) ? 4 : int'($urandom_range(0, 6));
      clear_model();
      push_frame(d, pe, pt, presc);
      push_idle(2);
      launch(d, pe, pt, 6'(presc), 1'b0);
      for (int i = 0; i < exp_tx.size(); i++) begin
        @(negedge clk);
        checks++;
        if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
          errors++;
          $display("FAIL parity frame %0d d=%h pe=%b pt=%b p=%0d cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                   n, d, pe, pt, presc, i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic pt;
    pt = 1'($urandom);
    clear_model();
    push_frame(8'h3C, 1'b1, pt, 3);
    push_idle(3);
    launch(8'h3C, 1'b1, pt, 6'd3, 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
      if (i == 10) begin
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = ~pt;
        bus.prescale   = 6'd1;
      end else if (i == 11) begin
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'h81;
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    push_frame(8'h55, 1'b0, 1'b0, 2);
    push_idle(1);
    push_frame(8'hAA, 1'b0, 1'b0, 2);
    push_idle(3);
    launch(8'h55, 1'b0, 1'b0, 6'd2, 1'b1);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
      if (i == 0)  bus.P_DATA = 8'hAA;
      if (i == 25) bus.DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    clear_model();
    push_frame(8'h5A, 1'b0, 1'b0, 4);
    launch(8'h5A, 1'b0, 1'b0, 6'd4, 1'b0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL reset_mid pre cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
    end
    // Now inside data bit 2 (a 0 bit); reset lands between clock edges.
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: tx=%b busy=%b required tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_model();
    push_idle(4);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL reset_no_resume cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
    end
    d = 8'($urandom);
    clear_model();
    push_frame(d, 1'b1, 1'b1, 2);
    push_idle(2);
    launch(d, 1'b1, 1'b1, 6'd2, 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge clk);
      checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL reset_new_frame d=%h cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                 d, i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_prescale_limits();
    logic [7:0] d;
    int         presc;
    for (int n = 0; n < 3; n++) begin
      presc = (n == 2) ? 63 : n;
      d     = (n == 2) ? 8'($urandom) : 8'h81;
      clear_model();
      push_frame(d, 1'b0, 1'b0, presc);
      push_idle(2);
      launch(d, 1'b0, 1'b0, 6'(presc), 1'b0);
      for (int i = 0; i < exp_tx.size(); i++) begin
        @(negedge clk);
        checks++;
        if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
          errors++;
          $display("FAIL prescale p=%0d d=%h cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                   presc, d, i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       pe, pt;
    int         presc;
    for (int n = 0; n < 8; n++) begin
      d     = 8'($urandom);
      pe    = 1'($urandom);
      pt    = 1'($urandom);
      presc = int'($urandom_range(0, 7));
      clear_model();
      push_frame(d, pe, pt, presc);
      push_idle(1);
      launch(d, pe, pt, 6'(presc), 1'b0);
      for (int i = 0; i < exp_tx.size(); i++) begin
        @(negedge clk);
        checks++;
        if (bus.TX_OUT !== exp_tx[i] || bus.Busy !== exp_busy[i]) begin
          errors++;
          $display("FAIL random frame %0d d=%h pe=%b pt=%b p=%0d cycle %0d: tx=%b busy=%b required tx=%b busy=%b",
                   n, d, pe, pt, presc, i, bus.TX_OUT, bus.Busy, exp_tx[i], exp_busy[i]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_prescale_limits();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
